cpu_mem_responder: RTL and testbench
====================================

// Module: cpu_mem_responder
// PURPOSE
// Memory-side responder for the pipelined cpu's memory interface: serves instruction fetch (port I),
// LOAD reads and STORE writes (port D) from one DEPTH x DATA_W true-dual-port array, 1-cycle read latency.
// After reset, an FSM zero-fills the array, then accepts a host program load, then enters RUN.
// Until RUN, fetch returns NOOP (all zeros); mem_ready holds the cpu in reset.
// PARAMETERS
// ADDR_W        11    address width, all ports
// DATA_W        32    data width
// DEPTH         2048  words implemented; must be <= 2**ADDR_W
// CLEAR_ON_RST  1     1: zero-fill array after reset; 0: skip straight to LOAD
// IFETCH_GATED  0     0: port I reads every RUN cycle; 1: only when read_mem_ir=1
// PORTS
// clk               in   1       clock, all logic on rising edge
// resetn            in   1       reset, synchronous, active-low
// read_mem_ir       in   1       instruction read enable (see IFETCH_GATED)
// mem_radrs_ir      in   ADDR_W  instruction read address
// instruction_fetch out  DATA_W  instruction read data
// read_mem_str      in   1       data read enable (LOAD)
// mem_radrs_LD      in   ADDR_W  data read address
// mem_store_data    out  DATA_W  data read data
// write_mem         in   1       data write enable (STORE)
// mem_wadrs         in   ADDR_W  data write address
// mem_wdata         in   DATA_W  data write data
// load_valid        in   1       host program word valid
// load_ready        out  1       host word accepted when load_valid & load_ready
// load_addr         in   ADDR_W  host word address
// load_data         in   DATA_W  host word data
// load_done         in   1       host pulse: program complete -> RUN
// mem_ready         out  1       1 only in RUN
// addr_err          out  1       sticky: an access had address >= DEPTH
// BEHAVIOUR
// - Reset (resetn=0 at edge): state=CLEAR (or LOAD if CLEAR_ON_RST=0), clear_cnt=0; instruction_fetch=0,
//   mem_store_data=0, load_ready=0, mem_ready=0, addr_err=0. Array contents are not reset. Reset
//   mid-CLEAR/LOAD/RUN aborts the current phase; any in-flight write is dropped.
// - CLEAR: writes 0 to clear_cnt, increments each cycle; on clear_cnt==DEPTH-1 the write happens and
//   state->LOAD next cycle (exactly DEPTH cycles). cpu ports ignored.
// - LOAD: load_ready=1. Accepted word written via port D same edge. load_done (with or without a
//   same-cycle load_valid, which is still written) -> RUN next cycle. cpu ports ignored.
// - RUN: mem_ready=1, load_ready=0, load_* ignored; state stays RUN until reset.
// - Port I (RUN): read at edge N -> instruction_fetch valid after edge N (1-cycle latency).
//   When not reading (gated off), output holds last value. Outside RUN, output forced to 0.
// - Port D reads: read_mem_str at edge N -> mem_store_data after edge N; holds when idle.
// - Port D writes: write_mem writes mem_wdata at edge N. If read_mem_str and write_mem both 1, write
//   wins, read ignored, mem_store_data holds.
// - Collision: port I reading address being written same edge returns new data (write-first bypass).
// - Address >= DEPTH: read returns 0, write dropped, addr_err set (sticky until reset).
//   Not reachable when DEPTH == 2**ADDR_W.
// STRUCTURE
// - Shared package cpu_pkg: ADDR_W/DATA_W defaults, NOOP word (32'h0), opcode localparams
//   (LOAD=3'b111 ... NOOP=3'b000), responder state encoding {CLEAR, LOAD, RUN}.
// - Sub-module dp_ram: 1 write/read port (D) + 1 read port (I), registered outputs,
//   write-first bypass; this block wraps it with FSM, clear counter, muxing and range check.
// TESTING
// - Reset, CLEAR_ON_RST=1, DEPTH=2048: mem_ready rises after exactly 2048+1 cycles into LOAD with load_done;
//   any address reads 0.
// - LOAD addr 5 = 32'hE000_0123, load_done, RUN: mem_radrs_ir=5 -> instruction_fetch=32'hE000_0123
//   one cycle later.
// - RUN: STORE addr 0x10 = 32'hDEAD_BEEF, next cycle LOAD addr 0x10 -> mem_store_data=32'hDEAD_BEEF after 1 cycle.
// - Same edge: write_mem addr 7 = 32'h1234_5678, port I reads 7 -> instruction_fetch=32'h1234_5678.
// - DEPTH=1024: write to addr 1500 -> addr_err=1, read addr 1500 returns 0, addr_err stays 1 until reset.
// - Assert resetn=0 mid-CLEAR (cnt=300): outputs zero, mem_ready=0, CLEAR restarts from 0.

Source files
------------

// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the cpu memory responder slice.
// Contents: default bus widths, the NOOP instruction word, opcode encodings
// and the responder phase encoding {CLEAR, LOAD, RUN}.
package cpu_mem_responder_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    // All-zero word decodes as NOOP; returned on the fetch port outside RUN
    localparam logic [31:0] NOOP_WORD = 32'h0000_0000;

    localparam logic [2:0] OP_LOAD = 3'b111;
    localparam logic [2:0] OP_NOOP = 3'b000;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } resp_state_e;

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Bus bundle between the cpu/host side (master) and the memory responder (slave).
// Carries instruction fetch port I, data port D (LOAD/STORE), the host program
// load channel and the status flags mem_ready / addr_err.
interface cpu_mem_responder_if
    import cpu_mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              read_mem_ir;
    logic [ADDR_W-1:0] mem_radrs_ir;
    logic [DATA_W-1:0] instruction_fetch;
    logic              read_mem_str;
    logic [ADDR_W-1:0] mem_radrs_LD;
    logic [DATA_W-1:0] mem_store_data;
    logic              write_mem;
    logic [ADDR_W-1:0] mem_wadrs;
    logic [DATA_W-1:0] mem_wdata;
    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_done;
    logic              mem_ready;
    logic              addr_err;

    modport master (
        output read_mem_ir, mem_radrs_ir, read_mem_str, mem_radrs_LD,
               write_mem, mem_wadrs, mem_wdata,
               load_valid, load_addr, load_data, load_done,
        input  instruction_fetch, mem_store_data, load_ready, mem_ready, addr_err
    );

    modport slave (
        input  read_mem_ir, mem_radrs_ir, read_mem_str, mem_radrs_LD,
               write_mem, mem_wadrs, mem_wdata,
               load_valid, load_addr, load_data, load_done,
        output instruction_fetch, mem_store_data, load_ready, mem_ready, addr_err
    );

endinterface

// File: rtl/cpu_mem_responder_dp_ram.sv
// DEPTH x DATA_W dual-port array: port D (write + read), port I (read only).
// Both read data outputs are registered (1-cycle latency) and hold when idle.
// Port I returns write data when it reads the address port D writes on the
// same edge. Addresses >= DEPTH read as 0 and are never written; range_err_s
// flags any such enabled access combinationally.
// Ports: clk, resetn (sync, active-low, clears read registers), d_we/d_waddr/
// d_wdata, d_re/d_raddr/d_rdata, i_re/i_clr/i_raddr/i_rdata, range_err_s.
module cpu_mem_responder_dp_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_waddr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_re,
    input  logic [ADDR_W-1:0] d_raddr,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              i_re,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              range_err_s
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] d_rdata_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic              d_wok_s;
    logic              d_rok_s;
    logic              i_rok_s;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    // Range qualification of each port and error detection
    always_comb begin
        d_wok_s     = in_range(d_waddr);
        d_rok_s     = in_range(d_raddr);
        i_rok_s     = in_range(i_raddr);
        range_err_s = (d_we & ~d_wok_s) | (d_re & ~d_rok_s) | (i_re & ~i_rok_s);
    end

    // Array write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (d_we && d_wok_s) begin
            mem_r[d_waddr[IDX_W-1:0]] <= d_wdata;
        end
    end

    // Port D read register, holds when not reading
    always_ff @(posedge clk) begin
        if (!resetn) begin
            d_rdata_r <= '0;
        end else if (d_re) begin
            d_rdata_r <= d_rok_s ? mem_r[d_raddr[IDX_W-1:0]] : '0;
        end
    end

    // Port I read register with write-first bypass and forced-zero clear
    always_ff @(posedge clk) begin
        if (!resetn || i_clr) begin
            i_rdata_r <= '0;
        end else if (i_re) begin
            if (!i_rok_s) begin
                i_rdata_r <= '0;
            end else if (d_we && d_wok_s && (d_waddr == i_raddr)) begin
                i_rdata_r <= d_wdata;
            end else begin
                i_rdata_r <= mem_r[i_raddr[IDX_W-1:0]];
            end
        end
    end

    assign d_rdata = d_rdata_r;
    assign i_rdata = i_rdata_r;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the pipelined cpu. After reset it zero-fills the
// array (optional), accepts a host program load, then serves instruction fetch
// and LOAD/STORE traffic in RUN. mem_ready is high only in RUN; addr_err is a
// sticky flag for any access at an address >= DEPTH.
// Ports: clk, resetn (sync, active-low), bus (cpu_mem_responder_if.slave).
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEPTH        = 2048,
    parameter int CLEAR_ON_RST = 1,
    parameter int IFETCH_GATED = 0
) (
    input  logic                clk,
    input  logic                resetn,
    cpu_mem_responder_if.slave  bus
);
    localparam resp_state_e    RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_LOAD;
    localparam logic [ADDR_W-1:0] LAST_L = ADDR_W'(DEPTH - 1);

    resp_state_e       state_r;
    resp_state_e       state_nxt_s;
    logic [ADDR_W-1:0] clear_cnt_r;
    logic              load_ready_r;
    logic              mem_ready_r;
    logic              addr_err_r;

    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic              ram_dre_s;
    logic              ram_ire_s;
    logic              ram_iclr_s;
    logic              range_err_s;

    // Next-phase decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clear_cnt_r == LAST_L) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_LOAD: begin
                if (bus.load_done) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = RST_STATE;
        endcase
    end

    // Port D write/read source selection per phase; writes are dropped during reset
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = '0;
        ram_wdata_s = '0;
        ram_dre_s   = 1'b0;
        ram_ire_s   = 1'b0;
        ram_iclr_s  = 1'b1;
        case (state_r)
            ST_CLEAR: begin
                ram_we_s    = resetn;
                ram_waddr_s = clear_cnt_r;
                ram_wdata_s = DATA_W'(NOOP_WORD);
            end
            ST_LOAD: begin
                ram_we_s    = resetn & bus.load_valid & load_ready_r;
                ram_waddr_s = bus.load_addr;
                ram_wdata_s = bus.load_data;
            end
            ST_RUN: begin
                ram_we_s    = resetn & bus.write_mem;
                ram_waddr_s = bus.mem_wadrs;
                ram_wdata_s = bus.mem_wdata;
                // A same-edge STORE wins over LOAD; the read is simply not issued
                ram_dre_s   = bus.read_mem_str & ~bus.write_mem;
                ram_ire_s   = (IFETCH_GATED != 0) ? bus.read_mem_ir : 1'b1;
                ram_iclr_s  = 1'b0;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    // Phase FSM, clear counter and registered status outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= RST_STATE;
            clear_cnt_r  <= '0;
            load_ready_r <= 1'b0;
            mem_ready_r  <= 1'b0;
            addr_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            if (state_r == ST_CLEAR) begin
                clear_cnt_r <= clear_cnt_r + ADDR_W'(1);
            end
            load_ready_r <= (state_nxt_s == ST_LOAD);
            mem_ready_r  <= (state_nxt_s == ST_RUN);
            addr_err_r   <= addr_err_r | range_err_s;
        end
    end

    cpu_mem_responder_dp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk         (clk),
        .resetn      (resetn),
        .d_we        (ram_we_s),
        .d_waddr     (ram_waddr_s),
        .d_wdata     (ram_wdata_s),
        .d_re        (ram_dre_s),
        .d_raddr     (bus.mem_radrs_LD),
        .d_rdata     (bus.mem_store_data),
        .i_re        (ram_ire_s),
        .i_clr       (ram_iclr_s),
        .i_raddr     (bus.mem_radrs_ir),
        .i_rdata     (bus.instruction_fetch),
        .range_err_s (range_err_s)
    );

    assign bus.load_ready = load_ready_r;
    assign bus.mem_ready  = mem_ready_r;
    assign bus.addr_err   = addr_err_r;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: a full-depth instance (DEPTH=2048)
// and a reduced-depth instance (DEPTH=1024) for the out-of-range behaviour.
module tb_cpu_mem_responder;
    logic clk;
    logic resetn;
    int   errors;
    int   checks;
    int   n;

    cpu_mem_responder_if #(.ADDR_W(11), .DATA_W(32)) bus  ();
    cpu_mem_responder_if #(.ADDR_W(11), .DATA_W(32)) bus2 ();

    cpu_mem_responder #(.ADDR_W(11), .DATA_W(32), .DEPTH(2048),
                        .CLEAR_ON_RST(1), .IFETCH_GATED(0))
        dut  (.clk(clk), .resetn(resetn), .bus(bus));

    cpu_mem_responder #(.ADDR_W(11), .DATA_W(32), .DEPTH(1024),
                        .CLEAR_ON_RST(1), .IFETCH_GATED(0))
        dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        bus.read_mem_ir = 1'b0;   bus.mem_radrs_ir = 11'd0;
        bus.read_mem_str = 1'b0;  bus.mem_radrs_LD = 11'd0;
        bus.write_mem = 1'b0;     bus.mem_wadrs = 11'd0;   bus.mem_wdata = 32'h0;
        bus.load_valid = 1'b0;    bus.load_addr = 11'd0;   bus.load_data = 32'h0;
        bus.load_done = 1'b0;
        bus2.read_mem_ir = 1'b0;  bus2.mem_radrs_ir = 11'd0;
        bus2.read_mem_str = 1'b0; bus2.mem_radrs_LD = 11'd0;
        bus2.write_mem = 1'b0;    bus2.mem_wadrs = 11'd0;  bus2.mem_wdata = 32'h0;
        bus2.load_valid = 1'b0;   bus2.load_addr = 11'd0;  bus2.load_data = 32'h0;
        bus2.load_done = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_ifetch",  bus.instruction_fetch, 32'h0);
        check("rst_sdata",   bus.mem_store_data,    32'h0);
        check("rst_ldready", {31'd0, bus.load_ready}, 32'd0);
        check("rst_mready",  {31'd0, bus.mem_ready},  32'd0);
        check("rst_aerr",    {31'd0, bus.addr_err},   32'd0);

        // Abort CLEAR at clear_cnt = 300
        resetn = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        check("mid_clr_ldready", {31'd0, bus.load_ready}, 32'd0);
        resetn = 1'b0;
        tick();
        check("mid_rst_mready",  {31'd0, bus.mem_ready},  32'd0);
        check("mid_rst_ldready", {31'd0, bus.load_ready}, 32'd0);
        check("mid_rst_ifetch",  bus.instruction_fetch,   32'h0);
        check("mid_rst_sdata",   bus.mem_store_data,      32'h0);

        // CLEAR restarts from 0: load_ready after exactly 2048 edges
        resetn = 1'b1;
        n = 0;
        while (bus.load_ready !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check("clear_len", n, 32'd2048);
        check("load_mready", {31'd0, bus.mem_ready}, 32'd0);

        // Program word with load_done in the same cycle -> RUN one edge later
        bus.load_valid = 1'b1; bus.load_addr = 11'd5; bus.load_data = 32'hE000_0123;
        bus.load_done = 1'b1;
        tick();
        n++;
        bus.load_valid = 1'b0; bus.load_done = 1'b0;
        check("run_mready",  {31'd0, bus.mem_ready},  32'd1);
        check("run_edges",   n, 32'd2049);
        check("run_ldready", {31'd0, bus.load_ready}, 32'd0);

        // Instruction fetch of loaded word, and of a cleared word
        bus.mem_radrs_ir = 11'd5;
        tick();
        check("ifetch_5", bus.instruction_fetch, 32'hE000_0123);
        bus.mem_radrs_ir = 11'd100;
        tick();
        check("ifetch_cleared", bus.instruction_fetch, 32'h0);

        // STORE then LOAD
        bus.write_mem = 1'b1; bus.mem_wadrs = 11'h10; bus.mem_wdata = 32'hDEAD_BEEF;
        tick();
        bus.write_mem = 1'b0;
        bus.read_mem_str = 1'b1; bus.mem_radrs_LD = 11'h10;
        tick();
        check("store_load", bus.mem_store_data, 32'hDEAD_BEEF);

        // STORE and LOAD together: write wins, read data holds
        bus.write_mem = 1'b1; bus.mem_wadrs = 11'h11; bus.mem_wdata = 32'h1111_2222;
        bus.mem_radrs_LD = 11'h11;
        tick();
        check("wr_wins_hold", bus.mem_store_data, 32'hDEAD_BEEF);
        bus.write_mem = 1'b0;
        tick();
        check("read_after_both", bus.mem_store_data, 32'h1111_2222);
        bus.read_mem_str = 1'b0; bus.mem_radrs_LD = 11'h10;
        tick();
        check("idle_hold", bus.mem_store_data, 32'h1111_2222);

        // Same-edge write/fetch collision returns new data
        bus.write_mem = 1'b1; bus.mem_wadrs = 11'd7; bus.mem_wdata = 32'h1234_5678;
        bus.mem_radrs_ir = 11'd7;
        tick();
        check("collision", bus.instruction_fetch, 32'h1234_5678);
        bus.write_mem = 1'b0;
        tick();
        check("after_collision", bus.instruction_fetch, 32'h1234_5678);

        // Host load channel ignored in RUN
        bus.load_valid = 1'b1; bus.load_addr = 11'd5; bus.load_data = 32'hFFFF_FFFF;
        tick();
        bus.load_valid = 1'b0; bus.mem_radrs_ir = 11'd5;
        tick();
        check("run_load_ignored", bus.instruction_fetch, 32'hE000_0123);
        check("main_aerr", {31'd0, bus.addr_err}, 32'd0);

        // Reduced depth instance: out-of-range accesses
        check("d2_mready", {31'd0, bus2.mem_ready}, 32'd1);
        check("d2_aerr0",  {31'd0, bus2.addr_err},  32'd0);
        bus2.write_mem = 1'b1; bus2.mem_wadrs = 11'd3; bus2.mem_wdata = 32'hCAFE_0003;
        tick();
        bus2.write_mem = 1'b0; bus2.read_mem_str = 1'b1; bus2.mem_radrs_LD = 11'd3;
        tick();
        check("d2_read3", bus2.mem_store_data, 32'hCAFE_0003);
        bus2.read_mem_str = 1'b0;
        bus2.write_mem = 1'b1; bus2.mem_wadrs = 11'd1500; bus2.mem_wdata = 32'hBAD0_BAD0;
        tick();
        bus2.write_mem = 1'b0;
        check("d2_aerr_set", {31'd0, bus2.addr_err}, 32'd1);
        bus2.read_mem_str = 1'b1; bus2.mem_radrs_LD = 11'd1500;
        tick();
        check("d2_read_oor", bus2.mem_store_data, 32'h0);
        bus2.mem_radrs_LD = 11'd476;
        tick();
        check("d2_no_alias", bus2.mem_store_data, 32'h0);
        bus2.read_mem_str = 1'b0;
        tick(); tick(); tick();
        check("d2_aerr_sticky", {31'd0, bus2.addr_err}, 32'd1);

        // Final reset clears sticky error and forces fetch back to NOOP
        resetn = 1'b0;
        tick();
        check("d2_aerr_rst",   {31'd0, bus2.addr_err}, 32'd0);
        check("end_ifetch",    bus.instruction_fetch,  32'h0);
        check("end_mready",    {31'd0, bus.mem_ready}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
